// File: rtl/mem_usage_counter.sv
// Event-buffer occupancy tracker: word usage, event count, throttle/halt FSM, sticky errors.
// Latency: usage/event_count/empty/full 1 cycle after the strobes; throttle/halt 1 further cycle.
// No backpressure: strobes are always accepted; illegal ones are ignored and flagged.
// Optional: define MEM_USAGE_ERRCNT_EN to add saturating ovf_count/unf_count outputs.
module mem_usage_counter #(
  parameter logic [17:0] CAPACITY = 18'd262143,
  parameter logic [17:0] HI_MARK  = 18'd229376,
  parameter logic [17:0] LO_MARK  = 18'd131072
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_word,
  input  logic        rd_word,
  input  logic        ev_wr,
  input  logic        ev_rd,
  input  logic        clear_err,
  output logic [17:0] current_mem_usage,
  output logic [15:0] event_count,
  output logic        empty,
  output logic        full,
  output logic        throttle,
  output logic        halt,
  output logic        overflow_err,
  output logic        underflow_err
`ifdef MEM_USAGE_ERRCNT_EN
  ,
  output logic [7:0]  ovf_count,
  output logic [7:0]  unf_count
`endif
);

  typedef enum logic [1:0] {
    ST_NORMAL   = 2'd0,
    ST_THROTTLE = 2'd1,
    ST_HALT     = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [17:0] r_usage;
  logic [17:0] w_usage_nxt;
  logic [15:0] r_ev_cnt;
  logic [15:0] w_ev_cnt_nxt;
  logic        r_empty;
  logic        r_full;
  logic        r_ovf_err;
  logic        r_unf_err;

  logic        w_ovf;
  logic        w_unf_word;
  logic        w_unf_ev;
  logic        w_unf;

  // Next word occupancy; a lone write at capacity or lone read at zero is dropped and flagged.
  always_comb begin
    w_usage_nxt = r_usage;
    w_ovf       = 1'b0;
    w_unf_word  = 1'b0;
    if (wr_word && !rd_word) begin
      if (r_usage == CAPACITY) begin
        w_ovf = 1'b1;
      end else begin
        w_usage_nxt = r_usage + 18'd1;
      end
    end else if (rd_word && !wr_word) begin
      if (r_usage == 18'd0) begin
        w_unf_word = 1'b1;
      end else begin
        w_usage_nxt = r_usage - 18'd1;
      end
    end
  end

  // Next event count; saturates silently at the top, flags a lone read at zero.
  always_comb begin
    w_ev_cnt_nxt = r_ev_cnt;
    w_unf_ev     = 1'b0;
    if (ev_wr && !ev_rd) begin
      if (r_ev_cnt != 16'hFFFF) begin
        w_ev_cnt_nxt = r_ev_cnt + 16'd1;
      end
    end else if (ev_rd && !ev_wr) begin
      if (r_ev_cnt == 16'd0) begin
        w_unf_ev = 1'b1;
      end else begin
        w_ev_cnt_nxt = r_ev_cnt - 16'd1;
      end
    end
  end

  assign w_unf = w_unf_word | w_unf_ev;

  // Occupancy registers; empty/full come from the next value so they line up with usage.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_usage  <= 18'd0;
      r_ev_cnt <= 16'd0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
    end else begin
      r_usage  <= w_usage_nxt;
      r_ev_cnt <= w_ev_cnt_nxt;
      r_empty  <= (w_usage_nxt == 18'd0);
      r_full   <= (w_usage_nxt == CAPACITY);
    end
  end

  // Sticky error flags; a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf_err <= 1'b0;
      r_unf_err <= 1'b0;
    end else begin
      r_ovf_err <= w_ovf | (r_ovf_err & ~clear_err);
      r_unf_err <= w_unf | (r_unf_err & ~clear_err);
    end
  end

  // Throttle state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_NORMAL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Throttle transitions act on registered usage; HALT always drains through THROTTLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_NORMAL: begin
        if (r_usage >= HI_MARK) begin
          w_state_nxt = ST_THROTTLE;
        end
      end
      ST_THROTTLE: begin
        if (r_usage == CAPACITY) begin
          w_state_nxt = ST_HALT;
        end else if (r_usage <= LO_MARK) begin
          w_state_nxt = ST_NORMAL;
        end
      end
      ST_HALT: begin
        if (r_usage < CAPACITY) begin
          w_state_nxt = ST_THROTTLE;
        end
      end
      default: begin
        w_state_nxt = ST_NORMAL;
      end
    endcase
  end

  assign current_mem_usage = r_usage;
  assign event_count       = r_ev_cnt;
  assign empty             = r_empty;
  assign full              = r_full;
  assign throttle          = (r_state != ST_NORMAL);
  assign halt              = (r_state == ST_HALT);
  assign overflow_err      = r_ovf_err;
  assign underflow_err     = r_unf_err;

`ifdef MEM_USAGE_ERRCNT_EN
  logic [7:0] r_ovf_cnt;
  logic [7:0] r_unf_cnt;

  // Saturating ignored-strobe counters; clearing in an error cycle leaves a count of one.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf_cnt <= 8'd0;
      r_unf_cnt <= 8'd0;
    end else if (clear_err) begin
      r_ovf_cnt <= w_ovf ? 8'd1 : 8'd0;
      r_unf_cnt <= w_unf ? 8'd1 : 8'd0;
    end else begin
      if (w_ovf && (r_ovf_cnt != 8'hFF)) begin
        r_ovf_cnt <= r_ovf_cnt + 8'd1;
      end
      if (w_unf && (r_unf_cnt != 8'hFF)) begin
        r_unf_cnt <= r_unf_cnt + 8'd1;
      end
    end
  end

  assign ovf_count = r_ovf_cnt;
  assign unf_count = r_unf_cnt;
`endif

endmodule

// File: tb/tb_mem_usage_counter.sv
// Bench for mem_usage_counter with a scaled-down buffer (CAPACITY 40, HI 35, LO 20)
// so fill/drain scenarios fit in a short run; expectations are queued by the stimulus
// and checked by an independent monitor on the falling edge of the cycle they are due.
module tb_mem_usage_counter;

  localparam logic [17:0] CAP = 18'd40;
  localparam logic [17:0] HI  = 18'd35;
  localparam logic [17:0] LO  = 18'd20;

  localparam int S_USAGE = 0;
  localparam int S_EVCNT = 1;
  localparam int S_EMPTY = 2;
  localparam int S_FULL  = 3;
  localparam int S_THR   = 4;
  localparam int S_HALT  = 5;
  localparam int S_OVF   = 6;
  localparam int S_UNF   = 7;
  localparam int S_OVFC  = 8;
  localparam int S_UNFC  = 9;

  typedef struct {
    int          due;
    string       name;
    int          sel;
    logic [17:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_word = 1'b0;
  logic        rd_word = 1'b0;
  logic        ev_wr = 1'b0;
  logic        ev_rd = 1'b0;
  logic        clear_err = 1'b0;
  logic [17:0] current_mem_usage;
  logic [15:0] event_count;
  logic        empty;
  logic        full;
  logic        throttle;
  logic        halt;
  logic        overflow_err;
  logic        underflow_err;
`ifdef MEM_USAGE_ERRCNT_EN
  logic [7:0]  ovf_count;
  logic [7:0]  unf_count;
`endif

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  mem_usage_counter #(
    .CAPACITY(CAP),
    .HI_MARK (HI),
    .LO_MARK (LO)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .wr_word          (wr_word),
    .rd_word          (rd_word),
    .ev_wr            (ev_wr),
    .ev_rd            (ev_rd),
    .clear_err        (clear_err),
    .current_mem_usage(current_mem_usage),
    .event_count      (event_count),
    .empty            (empty),
    .full             (full),
    .throttle         (throttle),
    .halt             (halt),
    .overflow_err     (overflow_err),
    .underflow_err    (underflow_err)
`ifdef MEM_USAGE_ERRCNT_EN
    ,
    .ovf_count        (ovf_count),
    .unf_count        (unf_count)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [17:0] actual(input int sel);
    case (sel)
      S_USAGE: return current_mem_usage;
      S_EVCNT: return {2'b00, event_count};
      S_EMPTY: return {17'd0, empty};
      S_FULL:  return {17'd0, full};
      S_THR:   return {17'd0, throttle};
      S_HALT:  return {17'd0, halt};
      S_OVF:   return {17'd0, overflow_err};
      S_UNF:   return {17'd0, underflow_err};
`ifdef MEM_USAGE_ERRCNT_EN
      S_OVFC:  return {10'd0, ovf_count};
      S_UNFC:  return {10'd0, unf_count};
`endif
      default: return 18'h3FFFF;
    endcase
  endfunction

  // Monitor: compare every expectation that has come due this cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      exp_t e;
      logic [17:0] a;
      e = q.pop_front();
      a = actual(e.sel);
      n_cmp = n_cmp + 1;
      if (e.due != cyc) begin
        n_bad = n_bad + 1;
        $display("FAIL %s: check missed its cycle (due %0d, now %0d)", e.name, e.due, cyc);
      end else if (a !== e.val) begin
        n_bad = n_bad + 1;
        $display("FAIL %s: got %0d, expected %0d (cycle %0d)", e.name, a, e.val, cyc);
      end
    end
  end

  task automatic chk(input string name, input int sel, input logic [17:0] val);
    exp_t e;
    e.due  = cyc;
    e.name = name;
    e.sel  = sel;
    e.val  = val;
    q.push_back(e);
  endtask

  // One clock of stimulus; returns #1 after the edge with all strobes idle again.
  task automatic step(input logic w, input logic r, input logic ew, input logic er,
                      input logic ce, input logic rs);
    wr_word   = w;
    rd_word   = r;
    ev_wr     = ew;
    ev_rd     = er;
    clear_err = ce;
    reset     = rs;
    @(posedge clk);
    #1;
    wr_word   = 1'b0;
    rd_word   = 1'b0;
    ev_wr     = 1'b0;
    ev_rd     = 1'b0;
    clear_err = 1'b0;
    reset     = 1'b0;
  endtask

  task automatic wr_n(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0);
  endtask

  task automatic rd_n(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset state
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("rst_usage", S_USAGE, 18'd0);
    chk("rst_evcnt", S_EVCNT, 18'd0);
    chk("rst_empty", S_EMPTY, 18'd1);
    chk("rst_full",  S_FULL,  18'd0);
    chk("rst_thr",   S_THR,   18'd0);
    chk("rst_halt",  S_HALT,  18'd0);
    chk("rst_ovf",   S_OVF,   18'd0);
    chk("rst_unf",   S_UNF,   18'd0);
`ifdef MEM_USAGE_ERRCNT_EN
    chk("rst_ovfc",  S_OVFC,  18'd0);
    chk("rst_unfc",  S_UNFC,  18'd0);
`endif

    // 5 writes, 2 reads -> 3
    wr_n(1);
    chk("wr_latency", S_USAGE, 18'd1);
    chk("wr_empty",   S_EMPTY, 18'd0);
    wr_n(4);
    rd_n(2);
    chk("wr5rd2_usage", S_USAGE, 18'd3);
    chk("wr5rd2_empty", S_EMPTY, 18'd0);
    chk("wr5rd2_ovf",   S_OVF,   18'd0);
    chk("wr5rd2_unf",   S_UNF,   18'd0);

    // Word underflow at zero, clear, clear racing a new error
    step(0, 0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 0);
    chk("unf_usage", S_USAGE, 18'd0);
    chk("unf_flag",  S_UNF,   18'd1);
    chk("unf_empty", S_EMPTY, 18'd1);
`ifdef MEM_USAGE_ERRCNT_EN
    chk("unf_cnt",   S_UNFC,  18'd1);
`endif
    step(0, 0, 0, 0, 1, 0);
    chk("unf_clear", S_UNF, 18'd0);
    step(0, 1, 0, 0, 1, 0);
    chk("unf_clr_race", S_UNF, 18'd1);
    step(0, 0, 0, 0, 1, 0);
    chk("unf_clear2", S_UNF, 18'd0);
    step(1, 1, 0, 0, 0, 0);
    chk("wrrd_empty_usage", S_USAGE, 18'd0);
    chk("wrrd_empty_unf",   S_UNF,   18'd0);
    chk("wrrd_empty_empty", S_EMPTY, 18'd1);

    // Fill through the high mark to capacity
    wr_n(34);
    chk("fill34_thr", S_THR, 18'd0);
    wr_n(1);
    chk("fill35_usage", S_USAGE, 18'd35);
    chk("fill35_thr",   S_THR,   18'd0);
    step(0, 0, 0, 0, 0, 0);
    chk("hi_thr",  S_THR,  18'd1);
    chk("hi_halt", S_HALT, 18'd0);
    wr_n(5);
    chk("cap_usage", S_USAGE, 18'd40);
    chk("cap_full",  S_FULL,  18'd1);
    chk("cap_halt0", S_HALT,  18'd0);
    step(0, 0, 0, 0, 0, 0);
    chk("cap_halt1", S_HALT, 18'd1);

    // Overflow at capacity, then legal write+read at capacity
    step(1, 0, 0, 0, 0, 0);
    chk("ovf_usage", S_USAGE, 18'd40);
    chk("ovf_flag",  S_OVF,   18'd1);
    chk("ovf_full",  S_FULL,  18'd1);
    step(1, 1, 0, 0, 0, 0);
    chk("wrrd_full_usage", S_USAGE, 18'd40);
    chk("wrrd_full_full",  S_FULL,  18'd1);
`ifdef MEM_USAGE_ERRCNT_EN
    chk("wrrd_full_ovfc",  S_OVFC,  18'd1);
`endif
    step(0, 0, 0, 0, 1, 0);
    chk("ovf_clear", S_OVF, 18'd0);
    step(1, 1, 0, 0, 0, 0);
    chk("wrrd_full_noerr", S_OVF,   18'd0);
    chk("wrrd_full_hold",  S_USAGE, 18'd40);

    // Drain from HALT down to the low mark
    rd_n(1);
    chk("drain1_usage", S_USAGE, 18'd39);
    chk("drain1_full",  S_FULL,  18'd0);
    chk("drain1_halt",  S_HALT,  18'd1);
    rd_n(1);
    chk("drain2_halt", S_HALT, 18'd0);
    chk("drain2_thr",  S_THR,  18'd1);
    rd_n(18);
    chk("drain20_usage", S_USAGE, 18'd20);
    chk("drain20_thr",   S_THR,   18'd1);
    step(0, 0, 0, 0, 0, 0);
    chk("lo_thr",  S_THR,  18'd0);
    chk("lo_halt", S_HALT, 18'd0);

    // Event counting and event underflow
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0);
    chk("ev_wr3", S_EVCNT, 18'd3);
    step(0, 0, 0, 1, 0, 0);
    chk("ev_rd1", S_EVCNT, 18'd2);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("ev_zero",     S_EVCNT, 18'd0);
    chk("ev_zero_unf", S_UNF,   18'd0);
    step(0, 0, 0, 1, 0, 0);
    chk("ev_unf_cnt",  S_EVCNT, 18'd0);
    chk("ev_unf_flag", S_UNF,   18'd1);
    step(0, 0, 1, 1, 0, 0);
    chk("ev_both_zero", S_EVCNT, 18'd0);

    // Reset wins over strobes mid-traffic
    wr_n(10);
    chk("pre_rst_usage", S_USAGE, 18'd30);
    step(1, 0, 1, 0, 0, 1);
    chk("rst_mid_usage", S_USAGE, 18'd0);
    chk("rst_mid_evcnt", S_EVCNT, 18'd0);
    chk("rst_mid_empty", S_EMPTY, 18'd1);
    chk("rst_mid_thr",   S_THR,   18'd0);
    chk("rst_mid_unf",   S_UNF,   18'd0);
    chk("rst_mid_ovf",   S_OVF,   18'd0);
    wr_n(1);
    chk("post_rst_usage", S_USAGE, 18'd1);

    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_usage_counter.md
MEM_USAGE_COUNTER -- requirements
Module: mem_usage_counter

Interface
REQ-001 SHALL have parameter CAPACITY, default 18'd262143, usable event-buffer depth in words.
REQ-002 SHALL have parameter HI_MARK, default 18'd229376, throttle-assert level.
REQ-003 SHALL have parameter LO_MARK, default 18'd131072, throttle-release level; LO_MARK < HI_MARK <= CAPACITY.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port wr_word  input  1  one word written to buffer this cycle.
REQ-007 SHALL have port rd_word  input  1  one word read from buffer this cycle.
REQ-008 SHALL have port ev_wr  input  1  end of one complete event written.
REQ-009 SHALL have port ev_rd  input  1  end of one complete event read out.
REQ-010 SHALL have port clear_err  input  1  clears sticky error flags.
REQ-011 SHALL have port current_mem_usage  output  18  registered word occupancy, feeds peak-usage monitor.
REQ-012 SHALL have port event_count  output  16  registered events held in buffer.
REQ-013 SHALL have port empty / full  output  1 each  usage==0 / usage==CAPACITY, registered.
REQ-014 SHALL have port throttle  output  1  state != NORMAL.
REQ-015 SHALL have port halt  output  1  state == HALT.
REQ-016 SHALL have port overflow_err / underflow_err  output  1 each  sticky error flags.

Function
REQ-017 SHALL update current_mem_usage on the clk edge sampling the strobes (1-cycle latency): +1 wr only, -1 rd only, unchanged both or neither.
REQ-018 SHALL ignore wr_word alone when usage==CAPACITY (usage holds) and set overflow_err.
REQ-019 SHALL ignore rd_word alone when usage==0 (usage holds) and set underflow_err.
REQ-020 SHALL treat wr_word&rd_word at full or empty as legal net-zero, no error.
REQ-021 SHALL update event_count likewise from ev_wr/ev_rd, saturating at 0 and 65535, setting underflow_err on ev_rd alone at 0; saturation at 65535 sets no flag.
REQ-022 SHALL derive empty/full from the next usage value so they are coincident with current_mem_usage.
REQ-023 SHALL run a state machine on registered usage (1 further cycle): NORMAL->THROTTLE when usage>=HI_MARK; THROTTLE->HALT when usage==CAPACITY; HALT->THROTTLE when usage<CAPACITY; THROTTLE->NORMAL when usage<=LO_MARK; no other transitions.
REQ-024 SHALL, from HALT with usage<=LO_MARK, go to THROTTLE first, NORMAL the following cycle.
REQ-025 SHALL clear both sticky flags on clear_err; an error event in the same cycle wins (flag set).

Reset
REQ-026 SHALL on reset set usage=0, event_count=0, empty=1, full=0, state NORMAL (throttle=0, halt=0), both error flags=0.
REQ-027 SHALL give reset priority over all strobes in the same cycle; reset mid-traffic discards counts with no error raised.

Configuration
REQ-028 SHALL, with macro MEM_USAGE_ERRCNT_EN defined, add outputs ovf_count[7:0] and unf_count[7:0], incremented per ignored overflow/underflow, saturating at 255, cleared by reset and clear_err.
REQ-029 SHALL, without MEM_USAGE_ERRCNT_EN, omit those ports and counter logic; all other behaviour identical.

Verification
REQ-030 SHALL cover: reset, then 5 wr_word pulses, 2 rd_word pulses -> usage=3, empty=0, no errors.
REQ-031 SHALL cover: usage=0, rd_word alone -> usage=0, underflow_err=1; clear_err -> underflow_err=0.
REQ-032 SHALL cover: usage=262143, wr_word alone -> usage holds, overflow_err=1; wr&rd together -> usage=262143, no new error (ovf_count=1 if enabled).
REQ-033 SHALL cover: fill to 229376 -> throttle=1 next cycle; to 262143 -> halt=1; drain to 131072 -> halt=0, then throttle=0 one cycle later.
REQ-034 SHALL cover: 3 ev_wr, 1 ev_rd, 3 ev_rd -> event_count 3, 2, 0, underflow_err=1.
REQ-035 SHALL cover: reset asserted with wr_word=1 at usage=1000 -> usage=0, state NORMAL, flags 0.
